pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage MIPS core. It merges per-stage stall requests into the 6-bit `stall` vector consumed by every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb). It sequences multi-cycle execute operations (div/mult) with an internal counter FSM. It also raises the pipeline flush and redirect PC when the mem stage reports an exception or eret.

---
 rtl/pipe_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//
// Pipeline control unit for the five-stage MIPS core. It merges the per-stage
// stall requests into one stall vector, sequences multi-cycle execute
// operations (div/mult) with a down-counter FSM, and raises flush plus a
// redirect PC when the mem stage reports an exception or eret.
//
// Parameters
//   DIV_CYCLES  RUN cycles of a multi-cycle op (2..255)
//   EXC_VECTOR  redirect PC for every non-eret exception
//
// Ports
//   clk                 single clock, rising edge
//   rst                 synchronous active-low reset
//   stallreq_from_if    fetch not ready
//   stallreq_from_id    load-use hazard
//   stallreq_from_ex    ex-stage single-cycle hold
//   stallreq_from_mem   data memory not ready
//   mc_start            ex stage begins a multi-cycle op
//   mc_cancel           abort the multi-cycle op in progress
//   excepttype[31:0]    mem-stage exception code, zero = none
//   cp0_epc[31:0]       eret return address
//   stall[5:0]          hold per stage: pc, if, id, ex, mem, wb
//   flush               discard all in-flight instructions
//   new_pc[31:0]        redirect target, valid while flush
//   mc_done             one-cycle pulse, multi-cycle result ready
//   busy                multi-cycle FSM not IDLE
//   stall_cycles[31:0]  cycles with stall[0]=1
//
// Build option
//   PIPE_CTRL_PERF_EN   when defined, stall_cycles is a live 32-bit counter;
//                       otherwise it is tied to zero and no register exists.
//
// Multi-cycle FSM
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no op; mc_start loads the counter and stalls this cycle
//   ST_RUN  | op in flight, ex-and-upstream held, counter counts down
//   ST_DONE | result ready, mc_done pulses, pipeline released
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int          DIV_CYCLES = 32,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic        mc_start,
  input  logic        mc_cancel,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        mc_done,
  output logic        busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mc_state_t;

  localparam logic [31:0] ERET_CODE = 32'h0000_000e;
  localparam logic [7:0]  MC_LOAD   = 8'(DIV_CYCLES - 1);

  localparam logic [5:0] PAT_IF  = 6'b000011;
  localparam logic [5:0] PAT_ID  = 6'b000111;
  localparam logic [5:0] PAT_EX  = 6'b001111;
  localparam logic [5:0] PAT_MC  = 6'b001111;
  localparam logic [5:0] PAT_MEM = 6'b011111;

  mc_state_t  state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       mc_hold;
  logic       exc_active;
  logic [5:0] stall_req;

  // Outputs are forced quiet while reset is asserted, so an exception code
  // sitting on the bus during reset does not produce a flush.
  assign exc_active = rst && (excepttype != 32'h0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mc_hold   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mc_start) begin
          // The start cycle already holds the pipe so the ex stage keeps
          // the operands steady.
          mc_hold = 1'b1;
          if (!exc_active) begin
            state_nxt = ST_RUN;
            cnt_nxt   = MC_LOAD;
          end
        end
      end
      ST_RUN: begin
        mc_hold = 1'b1;
        if (mc_cancel) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 8'h00;
        end else if (cnt == 8'h00) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt - 8'h01;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 8'h00;
      end
    endcase

    // A flush kills any op in flight, including one that just finished.
    if (exc_active) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = 8'h00;
    end
  end

  // Patterns are nested, so OR-ing them lets the most downstream request win.
  always_comb begin
    stall_req = 6'b000000;
    if (stallreq_from_if)  stall_req = stall_req | PAT_IF;
    if (stallreq_from_id)  stall_req = stall_req | PAT_ID;
    if (stallreq_from_ex)  stall_req = stall_req | PAT_EX;
    if (mc_hold)           stall_req = stall_req | PAT_MC;
    if (stallreq_from_mem) stall_req = stall_req | PAT_MEM;
  end

  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (rst) begin
      if (exc_active) begin
        flush  = 1'b1;
        new_pc = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
      end else begin
        stall = stall_req;
      end
    end
  end

  assign mc_done = (state == ST_DONE);
  assign busy    = (state != ST_IDLE);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_cnt <= 32'h0;
    end else if (stall[0]) begin
      perf_cnt <= perf_cnt + 32'h1;
    end
  end

  assign stall_cycles = perf_cnt;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int DIV = 4;

  logic        clk;
  logic        rst;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic        mc_start;
  logic        mc_cancel;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_done;
  logic        busy;
  logic [31:0] stall_cycles;

  pipe_ctrl #(.DIV_CYCLES(DIV), .EXC_VECTOR(32'h0000_0020)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_if  (stallreq_from_if),
    .stallreq_from_id  (stallreq_from_id),
    .stallreq_from_ex  (stallreq_from_ex),
    .stallreq_from_mem (stallreq_from_mem),
    .mc_start          (mc_start),
    .mc_cancel         (mc_cancel),
    .excepttype        (excepttype),
    .cp0_epc           (cp0_epc),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .mc_done           (mc_done),
    .busy              (busy),
    .stall_cycles      (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstv;
    logic        ifr;
    logic        idr;
    logic        exr;
    logic        memr;
    logic        start;
    logic        cancel;
    logic [31:0] exc;
    logic [31:0] epc;
  } in_t;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_done;
    logic        busy;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t tbl[14];

  function automatic in_t mk_in(logic ifr, logic idr, logic exr, logic memr,
                                logic start, logic cancel,
                                logic [31:0] exc, logic [31:0] epc);
    in_t r;
    r.rstv = 1'b1; r.ifr = ifr; r.idr = idr; r.exr = exr; r.memr = memr;
    r.start = start; r.cancel = cancel; r.exc = exc; r.epc = epc;
    return r;
  endfunction

  function automatic exp_t mk_exp(logic [5:0] s, logic f, logic [31:0] pc,
                                  logic d, logic b);
    exp_t r;
    r.stall = s; r.flush = f; r.new_pc = pc; r.mc_done = d; r.busy = b;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge, queue the expected
  // outputs, then compare at the falling edge of the same cycle.
  task automatic cyc(input string name, input in_t i, input exp_t e);
    exp_t got;
    rst = i.rstv;
    stallreq_from_if = i.ifr; stallreq_from_id = i.idr;
    stallreq_from_ex = i.exr; stallreq_from_mem = i.memr;
    mc_start = i.start; mc_cancel = i.cancel;
    excepttype = i.exc; cp0_epc = i.epc;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({name, " sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk({name, " stall"},   {26'h0, stall},   {26'h0, got.stall});
      chk({name, " flush"},   {31'h0, flush},   {31'h0, got.flush});
      chk({name, " new_pc"},  new_pc,           got.new_pc);
      chk({name, " mc_done"}, {31'h0, mc_done}, {31'h0, got.mc_done});
      chk({name, " busy"},    {31'h0, busy},    {31'h0, got.busy});
    end
    @(posedge clk);
    #1;
  endtask

  in_t  idle_in;
  in_t  tmp_in;
  exp_t z;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    idle_in = mk_in(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    z       = mk_exp(6'b000000, 0, 32'h0, 0, 0);

    tbl[0]  = '{mk_in(0,0,0,0,0,0,32'h0,32'h0),        mk_exp(6'b000000,0,32'h0,0,0)};
    tbl[1]  = '{mk_in(1,0,0,0,0,0,32'h0,32'h0),        mk_exp(6'b000011,0,32'h0,0,0)};
    tbl[2]  = '{mk_in(0,1,0,0,0,0,32'h0,32'h0),        mk_exp(6'b000111,0,32'h0,0,0)};
    tbl[3]  = '{mk_in(0,0,1,0,0,0,32'h0,32'h0),        mk_exp(6'b001111,0,32'h0,0,0)};
    tbl[4]  = '{mk_in(0,0,0,1,0,0,32'h0,32'h0),        mk_exp(6'b011111,0,32'h0,0,0)};
    tbl[5]  = '{mk_in(0,1,0,1,0,0,32'h0,32'h0),        mk_exp(6'b011111,0,32'h0,0,0)};
    tbl[6]  = '{mk_in(0,1,0,0,0,0,32'h0,32'h0),        mk_exp(6'b000111,0,32'h0,0,0)};
    tbl[7]  = '{mk_in(1,0,1,0,0,0,32'h0,32'h0),        mk_exp(6'b001111,0,32'h0,0,0)};
    tbl[8]  = '{mk_in(1,1,1,1,0,0,32'h0,32'h0),        mk_exp(6'b011111,0,32'h0,0,0)};
    tbl[9]  = '{mk_in(1,1,1,1,0,0,32'h8,32'h0),        mk_exp(6'b000000,1,32'h20,0,0)};
    tbl[10] = '{mk_in(0,0,0,0,0,0,32'he,32'h1234),     mk_exp(6'b000000,1,32'h1234,0,0)};
    tbl[11] = '{mk_in(0,1,0,1,0,0,32'he,32'hdead_beef),mk_exp(6'b000000,1,32'hdead_beef,0,0)};
    tbl[12] = '{mk_in(0,0,0,0,0,0,32'hffff_ffff,32'h1234), mk_exp(6'b000000,1,32'h20,0,0)};
    tbl[13] = '{mk_in(0,0,0,0,0,1,32'h0,32'h0),        mk_exp(6'b000000,0,32'h0,0,0)};

    // Reset with inputs active: outputs forced quiet, then state cleared.
    tmp_in = mk_in(1, 1, 1, 1, 1, 0, 32'h8, 32'h0);
    tmp_in.rstv = 1'b0;
    rst = 1'b0;
    stallreq_from_if = 1'b0; stallreq_from_id = 1'b0;
    stallreq_from_ex = 1'b0; stallreq_from_mem = 1'b0;
    mc_start = 1'b0; mc_cancel = 1'b0; excepttype = 32'h0; cp0_epc = 32'h0;
    @(posedge clk); #1;
    cyc("reset", tmp_in, z);
    chk("reset stall_cycles", stall_cycles, 32'h0);

    for (int k = 0; k < 14; k++) begin
      cyc($sformatf("vec%0d", k), tbl[k].i, tbl[k].e);
    end

    // Full multi-cycle op: hold t..t+4, done at t+5, idle at t+6.
    cyc("mc_t0", mk_in(0,0,0,0,1,0,32'h0,32'h0), mk_exp(6'b001111,0,32'h0,0,0));
    for (int k = 1; k <= DIV; k++)
      cyc($sformatf("mc_run%0d", k), idle_in, mk_exp(6'b001111,0,32'h0,0,1));
    cyc("mc_done", idle_in, mk_exp(6'b000000,0,32'h0,1,1));
    cyc("mc_idle", idle_in, z);

    // Cancel at the second RUN cycle.
    cyc("can_t0", mk_in(0,0,0,0,1,0,32'h0,32'h0), mk_exp(6'b001111,0,32'h0,0,0));
    cyc("can_r1", idle_in, mk_exp(6'b001111,0,32'h0,0,1));
    cyc("can_r2", mk_in(0,0,0,0,0,1,32'h0,32'h0), mk_exp(6'b001111,0,32'h0,0,1));
    for (int k = 0; k < DIV + 1; k++)
      cyc($sformatf("can_after%0d", k), idle_in, z);

    // Exception during RUN.
    cyc("exc_t0", mk_in(0,0,0,0,1,0,32'h0,32'h0), mk_exp(6'b001111,0,32'h0,0,0));
    cyc("exc_r1", idle_in, mk_exp(6'b001111,0,32'h0,0,1));
    cyc("exc_hit", mk_in(0,0,1,0,0,0,32'h8,32'h0), mk_exp(6'b000000,1,32'h20,0,1));
    cyc("exc_after", idle_in, z);
    // mc_start in a flush cycle is ignored.
    cyc("exc_start", mk_in(0,0,0,0,1,0,32'h4,32'h0), mk_exp(6'b000000,1,32'h20,0,0));
    cyc("exc_start_n", idle_in, z);

    // Mem stall overlapping RUN and DONE; op length unchanged; restart in RUN ignored.
    cyc("mem_t0", mk_in(0,0,0,0,1,0,32'h0,32'h0), mk_exp(6'b001111,0,32'h0,0,0));
    for (int k = 1; k <= DIV; k++)
      cyc($sformatf("mem_run%0d", k), mk_in(0,0,0,1,1,0,32'h0,32'h0),
          mk_exp(6'b011111,0,32'h0,0,1));
    cyc("mem_done", mk_in(0,0,0,1,0,0,32'h0,32'h0), mk_exp(6'b011111,0,32'h0,1,1));
    // Back-to-back start right after DONE.
    cyc("b2b_t0", mk_in(0,0,0,0,1,0,32'h0,32'h0), mk_exp(6'b001111,0,32'h0,0,0));
    cyc("b2b_r1", idle_in, mk_exp(6'b001111,0,32'h0,0,1));

    // Reset mid-RUN with every request high.
    tmp_in = mk_in(1,1,1,1,1,1,32'h8,32'h1234);
    tmp_in.rstv = 1'b0;
    cyc("rst_mid", tmp_in, mk_exp(6'b000000,0,32'h0,0,1));
    cyc("rst_hold", tmp_in, z);
    chk("rst_hold stall_cycles", stall_cycles, 32'h0);
    cyc("rst_rel_t0", mk_in(0,0,0,0,1,0,32'h0,32'h0), mk_exp(6'b001111,0,32'h0,0,0));
    for (int k = 1; k <= DIV; k++)
      cyc($sformatf("rst_rel_run%0d", k), idle_in, mk_exp(6'b001111,0,32'h0,0,1));
    cyc("rst_rel_done", idle_in, mk_exp(6'b000000,0,32'h0,1,1));

    // Stall cycle counter: 10 cycles of fetch stall, 3 of flush, after a reset.
    tmp_in = idle_in;
    tmp_in.rstv = 1'b0;
    cyc("perf_rst", tmp_in, z);
    for (int k = 0; k < 10; k++)
      cyc($sformatf("perf_if%0d", k), mk_in(1,0,0,0,0,0,32'h0,32'h0),
          mk_exp(6'b000011,0,32'h0,0,0));
    for (int k = 0; k < 3; k++)
      cyc($sformatf("perf_fl%0d", k), mk_in(1,0,0,0,0,0,32'h8,32'h0),
          mk_exp(6'b000000,1,32'h20,0,0));
`ifdef PIPE_CTRL_PERF_EN
    chk("perf stall_cycles", stall_cycles, 32'd10);
`else
    chk("perf stall_cycles", stall_cycles, 32'd0);
`endif

    chk("sb drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
